// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle RV32M multiply/divide unit with pipeline stall, flush and done handshake
module muldiv_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [4:0]  alu_op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);
  localparam logic [1:0] IDLE = 2'd0, MULT = 2'd1, DIVIDE = 2'd2, FIN = 2'd3;
  logic [1:0]  state;
  logic [5:0]  cnt;
  logic [4:0]  op;
  logic [31:0] a_q, b_q, res_q;
  logic        sa_q, sb_q, fast;
  logic [63:0] acc, prod;
  logic        in_m, in_div, in_rem, in_sa, in_sb, in_ovf, in_fast, accept;
  logic [31:0] fast_val, a_abs, b_abs, q_fix, r_fix, fin_val;
  logic [32:0] trial;
  // decode of the incoming request and of the latched operation; acc holds {remainder, quotient} while dividing
  always_comb begin
    in_m     = alu_op >= 5'd11 && alu_op <= 5'd18;
    in_div   = in_m && alu_op >= 5'd15;
    in_rem   = alu_op == 5'd17 || alu_op == 5'd18;
    in_sa    = alu_op == 5'd12 || alu_op == 5'd13 || alu_op == 5'd15 || alu_op == 5'd17;
    in_sb    = alu_op == 5'd12 || alu_op == 5'd15 || alu_op == 5'd17;
    in_ovf   = (alu_op == 5'd15 || alu_op == 5'd17) && operand_a == 32'h8000_0000 && operand_b == 32'hffff_ffff;
    in_fast  = in_div && (operand_b == 32'd0 || in_ovf);
    fast_val = in_ovf ? (in_rem ? 32'd0 : operand_a) : (in_rem ? operand_a : 32'hffff_ffff);
    a_abs    = in_sa && operand_a[31] ? -operand_a : operand_a;
    accept   = state == IDLE && start && in_m && !flush;
    busy     = state == MULT || state == DIVIDE;
    stall    = !rst && (accept || busy);
    done     = !rst && !flush && state == FIN;
    b_abs    = sb_q && b_q[31] ? -b_q : b_q;
    trial    = acc[63:31] - {1'b0, b_abs};
    prod     = {{32{sa_q && a_q[31]}}, a_q} * {{32{sb_q && b_q[31]}}, b_q};
    q_fix    = sa_q && (a_q[31] ^ b_q[31]) ? -acc[31:0] : acc[31:0];
    r_fix    = sa_q && a_q[31] ? -acc[63:32] : acc[63:32];
    fin_val  = fast ? acc[31:0] : op == 5'd11 ? acc[31:0] : op < 5'd15 ? acc[63:32] :
               (op == 5'd17 || op == 5'd18) ? r_fix : q_fix;
    result   = done ? fin_val : res_q;
  end
  // sequencing: accept, single-cycle multiply or fast path, 32 restoring divide steps, one-cycle finish
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      op    <= '0;
      a_q   <= '0;
      b_q   <= '0;
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
      fast  <= 1'b0;
      acc   <= '0;
      res_q <= '0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (accept) begin
      op    <= alu_op;
      a_q   <= operand_a;
      b_q   <= operand_b;
      sa_q  <= in_sa;
      sb_q  <= in_sb;
      fast  <= in_fast;
      acc   <= {32'd0, in_fast ? fast_val : a_abs};
      state <= in_div && !in_fast ? DIVIDE : MULT;
    end else if (state == MULT) begin
      acc   <= fast ? acc : prod;
      state <= FIN;
    end else if (state == DIVIDE) begin
      acc   <= trial[32] ? {acc[62:0], 1'b0} : {trial[31:0], acc[30:0], 1'b1};
      cnt   <= cnt == 6'd31 ? 6'd0 : cnt + 6'd1;
      state <= cnt == 6'd31 ? FIN : DIVIDE;
    end else if (state == FIN) begin
      res_q <= fin_val;
      state <= IDLE;
    end
  end
endmodule
